// File: rtl/int_rf_pkg.sv
// Shared constants, address-width helper and default address type for the
// integer register file and its scoreboard.
package int_rf_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  // Address width for n registers; never narrower than one bit.
  function automatic int rf_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_D = rf_aw(NREGS_D);

  typedef logic [AW_D-1:0] rf_addr_t;

endpackage

// File: rtl/int_regfile_sb_if.sv
// Decode/writeback bundle of the register file: read ports, issue, writeback,
// flush and the scoreboard status outputs.
interface int_regfile_sb_if
  import int_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD   = 3,
  parameter int NWR   = 1
);
  localparam int AW = rf_aw(NREGS);

  // There is no backpressure: issue and writeback are single-cycle strobes
  // (iss_valid_i, wb_valid_i[w]) that the register file always accepts on the
  // rising edge where they are high; reads are combinational with no handshake.
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_ready_o;
  logic                iss_valid_i;
  logic [AW-1:0]       iss_addr_i;
  logic [NWR-1:0]      wb_valid_i;
  logic [NWR*AW-1:0]   wb_addr_i;
  logic [NWR*XLEN-1:0] wb_data_i;
  logic                flush_i;
  logic [NREGS-1:0]    pend_vec_o;
  logic [AW:0]         pend_cnt_o;

  modport master (
    output rd_addr_i, iss_valid_i, iss_addr_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    input  rd_data_o, rd_ready_o, pend_vec_o, pend_cnt_o
  );

  modport slave (
    input  rd_addr_i, iss_valid_i, iss_addr_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    output rd_data_o, rd_ready_o, pend_vec_o, pend_cnt_o
  );

endinterface

// File: rtl/int_rf_scoreboard.sv
// Pending-bit scoreboard: flush beats issue beats writeback. The count register
// tracks the population of the next-state vector so it always matches pend_vec.
module int_rf_scoreboard
  import int_rf_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int NWR   = 1,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wb_valid,
  input  logic [NWR*AW-1:0] wb_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  pend_vec,
  output logic [AW:0]       pend_cnt
);

  logic [NREGS-1:0] pend_q, pend_nxt;
  logic [AW:0]      cnt_q, cnt_nxt;

  always_comb begin
    pend_nxt = pend_q;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wb_valid[w]) pend_nxt[wb_addr[w*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a same-cycle issue keeps its new producer outstanding.
      if (iss_valid) pend_nxt[iss_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign pend_vec = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/int_regfile_sb.sv
// Integer register file with NRD combinational read ports, NWR writeback ports,
// optional same-cycle write-to-read bypass and an integrated pending scoreboard.
module int_regfile_sb
  import int_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREGS  = NREGS_D,
  parameter int NRD    = 3,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input logic             clk_i,
  input logic             rsn_i,
  int_regfile_sb_if.slave rf
);

  localparam int AW = rf_aw(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   rd_sel [NRD];

  // Ascending port order makes the highest-index writer win on an address clash.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (rf.wb_valid_i[w] && (rf.wb_addr_i[w*AW +: AW] != '0)) begin
          regs_q[rf.wb_addr_i[w*AW +: AW]] <= rf.wb_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) rd_sel[k] = rf.rd_addr_i[k*AW +: AW];
  end

  always_comb begin
    rf.rd_data_o  = '0;
    rf.rd_ready_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rf.rd_data_o[k*XLEN +: XLEN] = regs_q[rd_sel[k]];
      rf.rd_ready_o[k]             = ~rf.pend_vec_o[rd_sel[k]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (rf.wb_valid_i[w] && (rf.wb_addr_i[w*AW +: AW] == rd_sel[k])) begin
            rf.rd_data_o[k*XLEN +: XLEN] = rf.wb_data_i[w*XLEN +: XLEN];
            rf.rd_ready_o[k]             = 1'b1;
          end
        end
      end
      if (rd_sel[k] == '0) begin
        rf.rd_data_o[k*XLEN +: XLEN] = '0;
        rf.rd_ready_o[k]             = 1'b1;
      end
    end
  end

  int_rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .iss_valid (rf.iss_valid_i),
    .iss_addr  (rf.iss_addr_i),
    .wb_valid  (rf.wb_valid_i),
    .wb_addr   (rf.wb_addr_i),
    .flush     (rf.flush_i),
    .pend_vec  (rf.pend_vec_o),
    .pend_cnt  (rf.pend_cnt_o)
  );

endmodule

// File: tb/tb_int_regfile_sb.sv
// Directed bench for int_regfile_sb with 3 read ports, 2 writeback ports and bypass.
module tb_int_regfile_sb;
  import int_rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic clk;
  logic rsn;
  int   n_tests;
  int   n_fail;

  int_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rf ();

  int_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .rf    (rf.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rf.rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic set_wb(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rf.wb_valid_i[w]             = 1'b1;
    rf.wb_addr_i[w*AW +: AW]     = a;
    rf.wb_data_i[w*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    rf.iss_valid_i = 1'b0;
    rf.iss_addr_i  = '0;
    rf.wb_valid_i  = '0;
    rf.wb_addr_i   = '0;
    rf.wb_data_i   = '0;
    rf.flush_i     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rsn = 1'b0;
    rf.rd_addr_i = '0;
    idle();
    #12 rsn = 1'b1;

    // Reset state, reads at x0..x2
    set_rd(0, 5'd0); set_rd(1, 5'd1); set_rd(2, 5'd2);
    #1;
    check("rst_rd_data", 64'(rf.rd_data_o), 64'd0);
    check("rst_rd_ready", 64'(rf.rd_ready_o), 64'b111);
    check("rst_pend_cnt", 64'(rf.pend_cnt_o), 64'd0);
    check("rst_pend_vec", 64'(rf.pend_vec_o), 64'd0);

    // Issue x5, then read it back as pending
    rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd5;
    tick();
    idle();
    set_rd(0, 5'd5);
    #1;
    check("iss5_ready", 64'(rf.rd_ready_o[0]), 64'd0);
    check("iss5_cnt", 64'(rf.pend_cnt_o), 64'd1);
    check("iss5_vec", 64'(rf.pend_vec_o), 64'h20);

    // Writeback x5 with same-cycle bypass
    set_wb(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("byp5_data", 64'(rf.rd_data_o[31:0]), 64'hDEADBEEF);
    check("byp5_ready", 64'(rf.rd_ready_o[0]), 64'd1);
    tick();
    idle();
    #1;
    check("wb5_data", 64'(rf.rd_data_o[31:0]), 64'hDEADBEEF);
    check("wb5_ready", 64'(rf.rd_ready_o[0]), 64'd1);
    check("wb5_cnt", 64'(rf.pend_cnt_o), 64'd0);

    // Issue and writeback x7 together: issue wins, data still commits
    rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd7;
    set_wb(0, 5'd7, 32'h11);
    tick();
    idle();
    set_rd(1, 5'd7);
    #1;
    check("x7_data", 64'(rf.rd_data_o[63:32]), 64'h11);
    check("x7_ready", 64'(rf.rd_ready_o[1]), 64'd0);
    check("x7_vec", 64'(rf.pend_vec_o), 64'h80);
    check("x7_cnt", 64'(rf.pend_cnt_o), 64'd1);

    // Both writeback ports hit x3 (x3 not pending): port 1 wins
    set_wb(0, 5'd3, 32'hAA);
    set_wb(1, 5'd3, 32'hBB);
    set_rd(2, 5'd3);
    #1;
    check("x3_byp_data", 64'(rf.rd_data_o[95:64]), 64'hBB);
    check("x3_byp_ready", 64'(rf.rd_ready_o[2]), 64'd1);
    tick();
    idle();
    #1;
    check("x3_data", 64'(rf.rd_data_o[95:64]), 64'hBB);
    check("x3_cnt", 64'(rf.pend_cnt_o), 64'd1);

    // Issue x1, x2, x4, then flush with a simultaneous issue of x6
    rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd1; tick();
    rf.iss_addr_i = 5'd2; tick();
    rf.iss_addr_i = 5'd4; tick();
    idle();
    #1;
    check("pre_flush_vec", 64'(rf.pend_vec_o), 64'h96);
    check("pre_flush_cnt", 64'(rf.pend_cnt_o), 64'd4);
    rf.flush_i = 1'b1; rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd6;
    tick();
    idle();
    #1;
    check("flush_vec", 64'(rf.pend_vec_o), 64'd0);
    check("flush_cnt", 64'(rf.pend_cnt_o), 64'd0);

    // x0 is hardwired: write and issue are ignored, count unchanged
    rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd9;
    tick();
    idle();
    rf.iss_valid_i = 1'b1; rf.iss_addr_i = 5'd0;
    set_wb(0, 5'd0, 32'h1234);
    set_rd(0, 5'd0);
    #1;
    check("x0_byp_data", 64'(rf.rd_data_o[31:0]), 64'd0);
    check("x0_byp_ready", 64'(rf.rd_ready_o[0]), 64'd1);
    tick();
    idle();
    #1;
    check("x0_data", 64'(rf.rd_data_o[31:0]), 64'd0);
    check("x0_ready", 64'(rf.rd_ready_o[0]), 64'd1);
    check("x0_cnt", 64'(rf.pend_cnt_o), 64'd1);
    check("x0_vec", 64'(rf.pend_vec_o), 64'h200);

    // Asynchronous reset pulse between edges
    set_rd(0, 5'd5); set_rd(1, 5'd7); set_rd(2, 5'd3);
    #2 rsn = 1'b0;
    #1;
    check("arst_data", 64'(rf.rd_data_o), 64'd0);
    check("arst_vec", 64'(rf.pend_vec_o), 64'd0);
    check("arst_cnt", 64'(rf.pend_cnt_o), 64'd0);
    check("arst_ready", 64'(rf.rd_ready_o), 64'b111);
    #1 rsn = 1'b1;
    tick();

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
